// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared RAM geometry, access size and FSM state types for the CPU memory path
package cpu_mem_pkg;

   localparam int MEM_AW = 9;
   localparam int MEM_DW = 32;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_DATA,
      WR_ISSUE,
      RESP
   } state_e;

   // Anything outside the RAM window, misaligned, or of size 2'b11 is rejected.
   function automatic logic access_illegal(input logic [1:0] size, input logic [31:0] addr);
      logic bad;
      bad = (addr[31:MEM_AW+2] != '0);
      case (size)
         BYTE:    bad = bad;
         HALF:    bad = bad | addr[0];
         WORD:    bad = bad | (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align
   import cpu_mem_pkg::*;
(
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [1:0]        offset_i,
   input  logic [MEM_DW-1:0] rdata_i,
   input  logic [MEM_DW-1:0] wdata_i,
   output logic [MEM_DW-1:0] load_data_o,
   output logic [MEM_DW-1:0] merged_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane   = rdata_i[{offset_i, 3'b000} +: 8];
      half_lane   = rdata_i[{offset_i[1], 4'b0000} +: 16];
      load_data_o = rdata_i;
      merged_o    = rdata_i;
      case (size_i)
         BYTE: begin
            load_data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         HALF: begin
            load_data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit in front of a 512x32 registered-read RAM
// Sub-word stores run as read-modify-write; illegal requests answer without touching the RAM.
module mem_access_unit
   import cpu_mem_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [31:0]       req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_error_o,
   output logic              memRead_o,
   output logic              memWrite_o,
   output logic [MEM_AW-1:0] memAddress_o,
   output logic [MEM_DW-1:0] memDataIn_o,
   input  logic [MEM_DW-1:0] memDataOut_i
);

   state_e             state_q;
   logic               write_q;
   logic               unsigned_q;
   logic [1:0]         size_q;
   logic [1:0]         offset_q;
   logic [31:0]        wdata_q;
   logic               mem_read_q;
   logic               mem_write_q;
   logic [MEM_AW-1:0]  mem_addr_q;
   logic [MEM_DW-1:0]  mem_wdata_q;
   logic               rsp_valid_q;
   logic               rsp_error_q;
   logic [31:0]        rsp_rdata_q;
   logic [MEM_DW-1:0]  load_data;
   logic [MEM_DW-1:0]  merged_data;

   mem_lane_align u_lane_align (
      .size_i      (size_q),
      .unsigned_i  (unsigned_q),
      .offset_i    (offset_q),
      .rdata_i     (memDataOut_i),
      .wdata_i     (wdata_q),
      .load_data_o (load_data),
      .merged_o    (merged_data)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         unsigned_q  <= 1'b0;
         size_q      <= 2'b00;
         offset_q    <= 2'b00;
         wdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  write_q     <= req_write_i;
                  unsigned_q  <= req_unsigned_i;
                  size_q      <= req_size_i;
                  offset_q    <= req_addr_i[1:0];
                  wdata_q     <= req_wdata_i;
                  mem_addr_q  <= req_addr_i[MEM_AW+1:2];
                  rsp_rdata_q <= '0;
                  rsp_error_q <= 1'b0;
                  if (access_illegal(req_size_i, req_addr_i)) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b1;
                  end else if (req_write_i && req_size_i == WORD) begin
                     state_q     <= WR_ISSUE;
                     mem_write_q <= 1'b1;
                     mem_wdata_q <= req_wdata_i;
                  end else begin
                     state_q    <= RD_ISSUE;
                     mem_read_q <= 1'b1;
                  end
               end
            end
            RD_ISSUE: state_q <= RD_DATA;
            RD_DATA: begin
               // RAM read data is valid here; either finish the load or write back the merged word.
               if (write_q) begin
                  state_q     <= WR_ISSUE;
                  mem_write_q <= 1'b1;
                  mem_wdata_q <= merged_data;
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= load_data;
               end
            end
            WR_ISSUE: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_error_o  = rsp_error_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign memRead_o    = mem_read_q;
   assign memWrite_o   = mem_write_q;
   assign memAddress_o = mem_addr_q;
   assign memDataIn_o  = mem_wdata_q;

endmodule
